// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: packs a 32-bit word stream into padded 512-bit SHA-256 blocks,
// drives the compression core block by block and returns the final digest.
module sha256_msg_sequencer (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         core_start,
    output logic         core_init,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);
    localparam logic [2:0] S_FILL = 3'd0;
    localparam logic [2:0] S_PAD  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]   r_state;
    logic [31:0]  r_buf [16];
    logic [3:0]   r_wptr;
    logic [63:0]  r_len;
    logic         r_first;
    logic         r_pad80;
    logic         r_final;
    logic         r_ended;
    logic [255:0] r_digest;
    logic         r_busy;
    logic [2:0]   w_n;
    logic [31:0]  w_last_word;
    logic [31:0]  w_pad_word;

    assign w_n = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    // The 0x80 terminator goes right after the last valid byte; a full last word owes it to the next slot.
    assign w_last_word = (w_n == 3'd0) ? 32'h8000_0000 :
                         (w_n == 3'd1) ? {in_data[31:24], 24'h80_0000} :
                         (w_n == 3'd2) ? {in_data[31:16], 16'h8000} :
                         (w_n == 3'd3) ? {in_data[31:8], 8'h80} : in_data;
    // r_final is raised while writing the high length word, so it marks slot 15 as the low length word.
    assign w_pad_word = r_pad80 ? 32'h8000_0000 :
                        (r_wptr == 4'd14) ? r_len[63:32] :
                        (r_wptr == 4'd15 && r_final) ? r_len[31:0] : 32'h0;

    assign in_ready     = !rst && r_state == S_FILL;
    assign core_start   = r_state == S_RUN;
    assign core_init    = core_start && r_first;
    assign digest_valid = r_state == S_DONE;
    assign digest       = r_digest;
    assign busy         = r_busy;

    for (genvar i = 0; i < 16; i++) begin : g_blk
        assign core_block[511-32*i -: 32] = r_buf[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FILL;
            for (int j = 0; j < 16; j++) r_buf[j] <= '0;
            r_wptr   <= '0;
            r_len    <= '0;
            r_first  <= 1'b1;
            r_pad80  <= 1'b0;
            r_final  <= 1'b0;
            r_ended  <= 1'b0;
            r_digest <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: if (in_valid) begin
                    r_buf[r_wptr] <= in_last ? w_last_word : in_data;
                    r_wptr        <= r_wptr + 4'd1;
                    r_len         <= r_len + (in_last ? {58'd0, w_n, 3'd0} : 64'd32);
                    r_busy        <= 1'b1;
                    if (in_last) begin
                        r_pad80 <= w_n == 3'd4;
                        r_ended <= 1'b1;
                        r_state <= (r_wptr == 4'd15) ? S_RUN : S_PAD;
                    end else if (r_wptr == 4'd15) begin
                        r_state <= S_RUN;
                    end
                end
                S_PAD: begin
                    r_buf[r_wptr] <= w_pad_word;
                    r_wptr        <= r_wptr + 4'd1;
                    r_pad80       <= 1'b0;
                    if (!r_pad80 && r_wptr == 4'd14) r_final <= 1'b1;
                    if (r_wptr == 4'd15) r_state <= S_RUN;
                end
                S_RUN: r_state <= S_WAIT;
                S_WAIT: if (core_done) begin
                    r_first <= 1'b0;
                    for (int j = 0; j < 16; j++) r_buf[j] <= '0;
                    r_wptr  <= '0;
                    if (r_final) r_digest <= core_digest;
                    r_state <= r_final ? S_DONE : (r_ended ? S_PAD : S_FILL);
                end
                S_DONE: begin
                    r_len   <= '0;
                    r_first <= 1'b1;
                    r_final <= 1'b0;
                    r_ended <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_FILL;
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
endmodule

// File: doc/sha256_msg_sequencer.md
# sha256_msg_sequencer

Streaming front end and block scheduler for the SHA-256 compression core. Accepts a byte-aligned message as 32-bit big-endian words over a valid/ready stream and builds 512-bit blocks. It appends FIPS 180-4 padding and the 64-bit bit length, issues each block to the core with a start/done handshake, and returns the final 256-bit digest. It replaces the fixed-width, combinationally padded input path, so messages of any length (up to 2^64−1 bits) can be hashed by one shared core.

## Interface
- No parameters; word width 32, block 512, digest 256, length counter 64 are fixed.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  message word valid.
- in_ready  out  1  sequencer accepts word this cycle.
- in_data  in  32  message word; first byte in [31:24].
- in_last  in  1  final word of message.
- in_bytes  in  3  valid bytes in final word, 0..4 (left-justified); ignored unless in_last.
- core_start  out  1  one-cycle pulse: core_block/core_init valid, begin compression.
- core_init  out  1  1 = first block of message (core loads IV), 0 = chain previous state.
- core_block  out  512  block; word 0 in [511:480].
- core_done  in  1  core finished current block; core_digest valid this cycle.
- core_digest  in  256  running hash state from core.
- digest  out  256  final message digest, held until next digest_valid.
- digest_valid  out  1  one-cycle pulse, digest updated.
- busy  out  1  message in progress (first word accepted through digest_valid).

## Operation
- States: FILL, PAD, RUN, WAIT, DONE. Reset → FILL.
- Block buffer buf[0..15], write pointer wptr (0..15), bit counter len (64-bit, wraps mod 2^64), flags first, pad80 (0x80 still owed), final.
- FILL: in_ready=1. On in_valid: buf[wptr]<=in_data, wptr++, len+=32, busy<=1.
  - in_last: n=in_bytes; len+=8n (not 32); stored word = bytes 0..n−1, byte n=0x80, rest 0; if n=4 store word unchanged and set pad80. → PAD (or RUN if wptr was 15).
  - Non-last word at wptr=15 → RUN (final=0).
- PAD: one word per cycle. If pad80: write 0x80000000, clear pad80. Else if wptr≤14 and entering index 14: write len[63:32], then index 15 len[31:0], set final, → RUN. Else write 0. If wptr reaches 16 (length did not fit: 0x80 landed at index ≥14) → RUN with final=0, then return to PAD.
- RUN: core_start=1 for one cycle, core_init=first, core_block=buf. → WAIT.
- WAIT: core_block held stable. On core_done: first<=0, clear buf, wptr<=0. If final → DONE; else → PAD if message ended (pad phase incomplete), else FILL.
- DONE: digest<=core_digest (captured on core_done), digest_valid=1 one cycle, reset len, first<=1, final<=0, busy<=0, → FILL.
- core_done outside WAIT ignored. in_valid outside FILL not accepted.
- in_last with in_bytes>4 treated as 4.

## Timing
- Reset values: in_ready 0 during rst cycle, 1 first cycle after; core_start 0, core_init 0, core_block 0, digest 0, digest_valid 0, busy 0.
- in_ready is a function of state only (state==FILL), no combinational path from in_valid.
- Last word accepted at cycle t with wptr=k≤13: PAD occupies 15−k cycles, core_start at t+16−k.
- Full non-last block: core_start the cycle after word 15 accepted.
- digest_valid exactly 1 cycle after final core_done; next message word accepted the cycle after that.
- Reset mid-operation: all state discarded, partial message lost, no digest_valid.

## Test plan
- "abc": one word 0x61626300, in_last, in_bytes=3 → one core_start, core_init=1, word0=0x61626380, words 1–14=0, word15=0x00000018; core_done digest D → digest=D, digest_valid 1 cycle later.
- Empty message: in_data=x, in_last, in_bytes=0 → block word0=0x80000000, words 1–15=0, core_init=1.
- 56-byte message (14 words, last in_bytes=4) → two blocks: block1 words 0–13 data, word14=0x80000000, word15=0, core_init=1; block2 words 0–13=0, word14=0, word15=0x000001C0, core_init=0.
- 64-byte message → block1 data only, block2 word0=0x80000000, word15=0x00000200; in_ready stays 0 from RUN through DONE.
- Spurious core_done in FILL and in_valid during WAIT → no state change, no word consumed, core_block unchanged.
- rst asserted during WAIT of a 2-block message → no digest_valid, busy=0, next "abc" hashes with core_init=1 and correct length 0x18.
